nmea_rmc_time_decoder: RTL
==========================

# nmea_rmc_time_decoder

Parametrised RMC-sentence time decoder, the successor to the single-talker GPRMC decoder. Sits between the UART byte receiver (byte + one-cycle strobe) and the 6-digit HC595 dynamic display. Accepts any two-letter talker ID (GP, GN, BD, GL…), optionally validates the NMEA checksum, and applies a compile-time timezone offset. Publishes local time as packed BCD and as a 20-bit decimal value for the display.

## Interface
- TZ_HOURS, 8: hour offset added to UTC, range 0..23, applied modulo 24.
- REQUIRE_FIX, 1: 1 = commit only sentences whose status field is 'A'; 0 = commit 'A' or 'V'.
- MAX_LEN, 82: maximum bytes from '$' to the end of the checksum or terminator; exceeding it aborts the sentence.
- sys_clk  in  1  single system clock, 50 MHz.
- sys_rst  in  1  reset, asynchronous, active-high.
- po_data  in  8  received byte, valid when po_flag is high.
- po_flag  in  1  one-cycle byte strobe.
- time_bcd  out  24  local hh:mm:ss as six BCD nibbles, hh in [23:16].
- time_dec  out  20  hh*10000 + mm*100 + ss, maximum 235959; drives the display data port.
- fix  out  1  status of the last committed sentence, 1 = 'A'.
- upd_pulse  out  1  one-cycle strobe when the outputs update.
- err_pulse  out  1  one-cycle strobe when a sentence is dropped.

## Operation
- Reset values: time_bcd = 0, time_dec = 0, fix = 0, upd_pulse = 0, err_pulse = 0, FSM in IDLE.
- Bytes are consumed only in cycles where po_flag = 1.
- FSM states and transitions:
  - IDLE: waits for '$'.
  - TALK: accepts two uppercase letters A–Z.
  - TYPE: requires "RMC".
  - FIELD: tracks commas.
    - Field 1 must begin with six ASCII digits, hhmmss; any following characters (".sss") are ignored.
    - Field 2 is a single 'A' or 'V'.
    - Later fields are skipped until '*'.
  - CK_HI, CK_LO: two hex digits; upper and lower case are both accepted.
  - COMMIT: updates the outputs.
- '$' in any non-IDLE state restarts the parse at TALK and raises err_pulse.
- Running checksum is the XOR of every byte strictly between '$' and '*'.
- Drop conditions (return to IDLE, raise err_pulse, leave outputs unchanged):
  - bad talker or type;
  - non-digit or fewer than six digits in field 1, including an empty field (",,");
  - hh > 23, mm > 59, or ss > 59;
  - status not 'A'/'V', or status 'V' when REQUIRE_FIX = 1;
  - byte count > MAX_LEN;
  - checksum mismatch or non-hex checksum character.
- Hour adjust: local_h = utc_h + TZ_HOURS, minus 24 if the sum is ≥ 24. Date is not tracked.
- time_dec is built from binary fields: h*10000 + m*100 + s, all unsigned, 20 bits.

## Timing
- Terminating byte accepted in cycle N. This is the second checksum digit, or '*' when the checksum check is compiled out.
- Cycle N+1: FSM is in COMMIT; timezone adjust and binary conversion are registered.
- Cycle N+2: time_bcd, time_dec and fix take their new values, and upd_pulse is high for exactly this cycle.
- A po_flag arriving during COMMIT is processed normally. The UART spacing of ≥ 5208 cycles makes this theoretical, but RTL must not lose it.
- err_pulse is high in the cycle after the offending byte. It never coincides with upd_pulse for the same sentence.
- Reset asserted mid-sentence: outputs clear immediately (asynchronous), the partial sentence is discarded, and no pulses are issued.

## Configuration
- NMEA_CHECKSUM_EN defined:
  - '*' must be followed by two hex digits matching the running XOR; otherwise the sentence is dropped.
  - Sentences with no '*' before CR are dropped.
- NMEA_CHECKSUM_EN undefined:
  - the XOR logic and the CK_HI/CK_LO states are absent;
  - '*' or CR ends the sentence and moves the FSM to COMMIT.

## Structure
- Shared package nmea_pkg holds:
  - FSM state enum;
  - ASCII constants ('$', ',', '*', CR, 'A', 'V', 'R', 'M', 'C');
  - the hex-to-nibble function.
- Sub-module rmc_time_convert takes the registered hh/mm/ss BCD and TZ_HOURS and returns the adjusted time_bcd and time_dec. This is purely the COMMIT-stage datapath.

## Test plan
- "$GPRMC,023456.00,A,…*cs" with correct cs, TZ_HOURS = 8 -> upd_pulse at N+2, time_bcd = 0x103456, time_dec = 103456, fix = 1.
- "$GNRMC,183000.00,A,…" with correct cs, TZ_HOURS = 8 -> hour wraps: time_bcd = 0x023000, time_dec = 23000.
- Same sentence as the first case, checksum +1 -> err_pulse, outputs hold their previous values; with NMEA_CHECKSUM_EN undefined -> commits.
- "$GPRMC,,V,,,…" and "$GPRMC,023456,V,…" with REQUIRE_FIX = 1 -> err_pulse, no update. With REQUIRE_FIX = 0, the second sentence commits with fix = 0.
- "$GPRMC,0234" followed by a new '$' and a valid sentence -> one err_pulse, then a correct update from the second sentence.
- Reset asserted in the middle of a valid sentence, then a full valid sentence -> outputs 0 during reset, no pulses for the first sentence, correct update for the second.

Source files
------------

// File: rtl/nmea_pkg.sv
// Shared FSM state type, ASCII constants and hex helper for the RMC time decoder.
// The checksum states exist only when NMEA_CHECKSUM_EN is defined.
package nmea_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTalk,
    StType,
    StField,
`ifdef NMEA_CHECKSUM_EN
    StCkHi,
    StCkLo,
`endif
    StCommit
  } state_e;

  localparam logic [7:0] ChDollar = 8'h24;
  localparam logic [7:0] ChComma  = 8'h2C;
  localparam logic [7:0] ChStar   = 8'h2A;
  localparam logic [7:0] ChCr     = 8'h0D;
  localparam logic [7:0] ChA      = 8'h41;
  localparam logic [7:0] ChV      = 8'h56;
  localparam logic [7:0] ChR      = 8'h52;
  localparam logic [7:0] ChM      = 8'h4D;
  localparam logic [7:0] ChC      = 8'h43;

  // Returns {valid, nibble}; accepts 0-9, A-F and a-f.
  function automatic logic [4:0] hex_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = 5'b0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

endpackage

// File: rtl/rmc_time_convert.sv
// COMMIT-stage datapath: applies the timezone offset to validated BCD hh:mm:ss and
// produces both the packed BCD and the hh*10000 + mm*100 + ss decimal value.
module rmc_time_convert #(
  parameter int unsigned TZ_HOURS = 8
) (
  input  logic [7:0]  hh_bcd,
  input  logic [7:0]  mm_bcd,
  input  logic [7:0]  ss_bcd,
  output logic [23:0] time_bcd,
  output logic [19:0] time_dec
);

  localparam logic [5:0] Tz = 6'(TZ_HOURS % 24);

  logic [5:0] utc_h, sum_h;
  logic [4:0] loc_h;
  logic [6:0] min_b, sec_b;
  logic [3:0] h_tens, h_ones;

  always_comb begin
    utc_h = 6'(hh_bcd[7:4]) * 6'd10 + 6'(hh_bcd[3:0]);
    sum_h = utc_h + Tz;
    loc_h = (sum_h >= 6'd24) ? 5'(sum_h - 6'd24) : sum_h[4:0];
    min_b = 7'(mm_bcd[7:4]) * 7'd10 + 7'(mm_bcd[3:0]);
    sec_b = 7'(ss_bcd[7:4]) * 7'd10 + 7'(ss_bcd[3:0]);
    if (loc_h >= 5'd20) begin
      h_tens = 4'd2;
      h_ones = 4'(loc_h - 5'd20);
    end else if (loc_h >= 5'd10) begin
      h_tens = 4'd1;
      h_ones = 4'(loc_h - 5'd10);
    end else begin
      h_tens = 4'd0;
      h_ones = loc_h[3:0];
    end
    time_bcd = {h_tens, h_ones, mm_bcd, ss_bcd};
    time_dec = 20'(loc_h) * 20'd10000 + 20'(min_b) * 20'd100 + 20'(sec_b);
  end

endmodule

// File: rtl/nmea_rmc_time_decoder.sv
// Parses $xxRMC sentences from a UART byte stream and publishes local time.
// Define NMEA_CHECKSUM_EN to require and verify the *hh checksum.
module nmea_rmc_time_decoder
  import nmea_pkg::*;
#(
  parameter int unsigned TZ_HOURS    = 8,
  parameter int unsigned REQUIRE_FIX = 1,
  parameter int unsigned MAX_LEN     = 82
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  po_data,
  input  logic        po_flag,
  output logic [23:0] time_bcd,
  output logic [19:0] time_dec,
  output logic        fix,
  output logic        upd_pulse,
  output logic        err_pulse
);

  localparam logic [8:0] MaxLen = 9'(MAX_LEN);
`ifdef NMEA_CHECKSUM_EN
  localparam state_e StEnd = StCkHi;
`else
  localparam state_e StEnd = StCommit;
`endif

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [1:0]  field_q, field_d;   // saturates at 3: all later fields are skipped
  logic        stat_q, stat_d, afix_q, afix_d;
  logic [23:0] hms_q, hms_d;
  logic [7:0]  len_q, len_d;
  logic [8:0]  len_inc;
  logic        drop, upd_d, err_d;
  logic        is_digit, is_upper, range_ok, term_ok;
  logic [7:0]  type_ch;
  logic [23:0] conv_bcd;
  logic [19:0] conv_dec;
`ifdef NMEA_CHECKSUM_EN
  logic [7:0]  cks_q, cks_d;
  logic [3:0]  ckhi_q, ckhi_d;
  logic [4:0]  hex;
  assign hex = hex_nibble(po_data);
`endif

  assign is_digit = (po_data >= 8'h30) && (po_data <= 8'h39);
  assign is_upper = (po_data >= 8'h41) && (po_data <= 8'h5A);
  assign range_ok = (hms_q[23:16] <= 8'h23) && (hms_q[15:8] <= 8'h59) && (hms_q[7:0] <= 8'h59);
  assign term_ok  = (field_q == 2'd3) || ((field_q == 2'd2) && stat_q);
  assign type_ch  = (idx_q == 3'd0) ? ChR : (idx_q == 3'd1) ? ChM : ChC;
  assign len_inc  = {1'b0, len_q} + 9'd1;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      field_q <= '0;
      stat_q  <= 1'b0;
      afix_q  <= 1'b0;
      hms_q   <= '0;
      len_q   <= '0;
`ifdef NMEA_CHECKSUM_EN
      cks_q   <= '0;
      ckhi_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      field_q <= field_d;
      stat_q  <= stat_d;
      afix_q  <= afix_d;
      hms_q   <= hms_d;
      len_q   <= len_d;
`ifdef NMEA_CHECKSUM_EN
      cks_q   <= cks_d;
      ckhi_q  <= ckhi_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    field_d = field_q;
    stat_d  = stat_q;
    afix_d  = afix_q;
    hms_d   = hms_q;
    len_d   = len_q;
    drop    = 1'b0;
`ifdef NMEA_CHECKSUM_EN
    cks_d   = cks_q;
    ckhi_d  = ckhi_q;
`endif
    if (state_q == StCommit) state_d = StIdle;
    if (po_flag) begin
      if (po_data == ChDollar) begin
        // A '$' always starts a fresh sentence; it is an error only mid-sentence.
        drop    = (state_q != StIdle) && (state_q != StCommit);
        state_d = StTalk;
        idx_d   = '0;
        field_d = '0;
        stat_d  = 1'b0;
        afix_d  = 1'b0;
        len_d   = 8'd1;
`ifdef NMEA_CHECKSUM_EN
        cks_d   = '0;
`endif
      end else if (state_q != StIdle && state_q != StCommit) begin
        if (len_inc > MaxLen) begin
          drop = 1'b1;
        end else begin
          len_d = len_inc[7:0];
          case (state_q)
            StTalk: begin
              if (is_upper) begin
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd1) begin
                  state_d = StType;
                  idx_d   = '0;
                end
              end else drop = 1'b1;
            end
            StType: begin
              if (po_data == type_ch) begin
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd2) begin
                  state_d = StField;
                  idx_d   = '0;
                end
              end else drop = 1'b1;
            end
            StField: begin
              if (po_data == ChStar) begin
                if (term_ok) state_d = StEnd;
                else drop = 1'b1;
              end else if (po_data == ChCr) begin
`ifdef NMEA_CHECKSUM_EN
                drop = 1'b1;
`else
                if (term_ok) state_d = StCommit;
                else drop = 1'b1;
`endif
              end else begin
                case (field_q)
                  2'd0: begin
                    if (po_data == ChComma) field_d = 2'd1;
                    else drop = 1'b1;
                  end
                  2'd1: begin
                    if (po_data == ChComma) begin
                      if (idx_q == 3'd6 && range_ok) field_d = 2'd2;
                      else drop = 1'b1;
                    end else if (idx_q != 3'd6) begin
                      if (is_digit) begin
                        hms_d = {hms_q[19:0], po_data[3:0]};
                        idx_d = idx_q + 3'd1;
                      end else drop = 1'b1;
                    end
                  end
                  2'd2: begin
                    if (po_data == ChComma) begin
                      if (stat_q) field_d = 2'd3;
                      else drop = 1'b1;
                    end else if (!stat_q && po_data == ChA) begin
                      stat_d = 1'b1;
                      afix_d = 1'b1;
                    end else if (!stat_q && po_data == ChV && REQUIRE_FIX == 0) begin
                      stat_d = 1'b1;
                    end else drop = 1'b1;
                  end
                  default: ;
                endcase
              end
            end
`ifdef NMEA_CHECKSUM_EN
            StCkHi: begin
              if (hex[4]) begin
                ckhi_d  = hex[3:0];
                state_d = StCkLo;
              end else drop = 1'b1;
            end
            StCkLo: begin
              if (hex[4] && {ckhi_q, hex[3:0]} == cks_q) state_d = StCommit;
              else drop = 1'b1;
            end
`endif
            default: ;
          endcase
`ifdef NMEA_CHECKSUM_EN
          if (po_data != ChStar && (state_q inside {StTalk, StType, StField})) begin
            cks_d = cks_q ^ po_data;
          end
`endif
        end
        if (drop) state_d = StIdle;
      end
    end
  end

  always_comb begin
    upd_d = (state_q == StCommit);
    err_d = drop;
  end

  rmc_time_convert #(
    .TZ_HOURS (TZ_HOURS)
  ) u_convert (
    .hh_bcd   (hms_q[23:16]),
    .mm_bcd   (hms_q[15:8]),
    .ss_bcd   (hms_q[7:0]),
    .time_bcd (conv_bcd),
    .time_dec (conv_dec)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      time_bcd  <= '0;
      time_dec  <= '0;
      fix       <= 1'b0;
      upd_pulse <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      upd_pulse <= upd_d;
      err_pulse <= err_d;
      if (upd_d) begin
        time_bcd <= conv_bcd;
        time_dec <= conv_dec;
        fix      <= afix_q;
      end
    end
  end

endmodule
